// File: rtl/subtractor_bla_pipe_pkg.sv
// Shared constants and types for the two-stage borrow-lookahead subtractor.
package subtractor_bla_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 4;
    localparam int HALF      = DEF_WIDTH / 2;
    localparam int NGRP      = HALF / DEF_GROUP;

    typedef struct packed {
        logic bout;
        logic n;
        logic z;
        logic v;
    } flags_t;

    localparam flags_t FLAGS_RST = '{bout: 1'b0, n: 1'b0, z: 1'b1, v: 1'b0};

    // Signed overflow of a subtraction: operands differ in sign and the result
    // sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/subtractor_bla_pipe_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
interface subtractor_bla_pipe_if
    import subtractor_bla_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_bin;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_d;
    logic             o_bout;
    logic             o_n;
    logic             o_z;
    logic             o_v;

    modport slave (
        input  i_valid, i_a, i_b, i_bin, i_ready,
        output o_ready, o_valid, o_d, o_bout, o_n, o_z, o_v
    );

    modport master (
        output i_valid, i_a, i_b, i_bin, i_ready,
        input  o_ready, o_valid, o_d, o_bout, o_n, o_z, o_v
    );
endinterface

// File: rtl/subtractor_bla_pipe_bla_block_4bit.sv
// One borrow-lookahead group: per-bit difference plus the group borrow-out.
module bla_block_4bit
    import subtractor_bla_pipe_pkg::*;
#(
    parameter int GROUP_W = DEF_GROUP
) (
    output logic               o_b,
    output logic [GROUP_W-1:0] o_d,
    input  logic [GROUP_W-1:0] i_a,
    input  logic [GROUP_W-1:0] i_b,
    input  logic               i_b_in
);
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic               gacc;
    logic               pacc;

    assign g = ~i_a & i_b;
    assign p = ~(i_a ^ i_b);

    // Borrow into each bit is the prefix (G,P) of the lower bits applied to
    // the group borrow-in; the final prefix is the group (G,P).
    always_comb begin
        gacc = 1'b0;
        pacc = 1'b1;
        o_d  = '0;
        for (int k = 0; k < GROUP_W; k++) begin
            o_d[k] = i_a[k] ^ i_b[k] ^ (gacc | (pacc & i_b_in));
            gacc   = g[k] | (p[k] & gacc);
            pacc   = pacc & p[k];
        end
        o_b = gacc | (pacc & i_b_in);
    end

endmodule

// File: rtl/subtractor_bla_pipe.sv
// Two-stage borrow-lookahead subtractor: lower half in stage 1, upper half and
// flags in stage 2, valid/ready on both sides, one operation per cycle.
module subtractor_bla_pipe
    import subtractor_bla_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    subtractor_bla_pipe_if.slave bus
);
    localparam int HALF_W = WIDTH / 2;
    localparam int NGRP_W = HALF_W / GROUP;

    if ((WIDTH % (2 * GROUP)) != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of 2*GROUP");
    end

    logic              s1_adv;
    logic              s2_adv;
    logic              accept;

    logic              s1_valid_q;
    logic [HALF_W-1:0] s1_dlo_q;
    logic              s1_mid_q;
    logic [HALF_W-1:0] s1_ahi_q;
    logic [HALF_W-1:0] s1_bhi_q;

    logic              s2_valid_q;
    logic [WIDTH-1:0]  d_q;
    flags_t            flags_q;

    logic [NGRP_W:0]   lo_bc;
    logic [NGRP_W:0]   hi_bc;
    logic [HALF_W-1:0] dlo_d;
    logic [HALF_W-1:0] dhi_d;
    logic [WIDTH-1:0]  d_d;
    flags_t            flags_d;

    assign s2_adv = ~s2_valid_q | bus.i_ready;
    assign s1_adv = ~s1_valid_q | s2_adv;
    assign accept = bus.i_valid & bus.o_ready;

    // Gated by reset so nothing is offered or taken while reset is held.
    assign bus.o_ready = s1_adv & ~i_rst;
    assign bus.o_valid = s2_valid_q & ~i_rst;

    assign lo_bc[0] = bus.i_bin;
    assign hi_bc[0] = s1_mid_q;

    for (genvar gi = 0; gi < NGRP_W; gi++) begin : g_grp
        bla_block_4bit #(.GROUP_W(GROUP)) u_lo (
            .o_b    (lo_bc[gi+1]),
            .o_d    (dlo_d[gi*GROUP +: GROUP]),
            .i_a    (bus.i_a[gi*GROUP +: GROUP]),
            .i_b    (bus.i_b[gi*GROUP +: GROUP]),
            .i_b_in (lo_bc[gi])
        );
        bla_block_4bit #(.GROUP_W(GROUP)) u_hi (
            .o_b    (hi_bc[gi+1]),
            .o_d    (dhi_d[gi*GROUP +: GROUP]),
            .i_a    (s1_ahi_q[gi*GROUP +: GROUP]),
            .i_b    (s1_bhi_q[gi*GROUP +: GROUP]),
            .i_b_in (hi_bc[gi])
        );
    end

    always_comb begin
        d_d          = {dhi_d, s1_dlo_q};
        flags_d.bout = hi_bc[NGRP_W];
        flags_d.n    = d_d[WIDTH-1];
        flags_d.z    = ~|d_d;
        flags_d.v    = sub_ovf(s1_ahi_q[HALF_W-1], s1_bhi_q[HALF_W-1], d_d[WIDTH-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_dlo_q   <= '0;
            s1_mid_q   <= 1'b0;
            s1_ahi_q   <= '0;
            s1_bhi_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_dlo_q <= dlo_d;
                s1_mid_q <= lo_bc[NGRP_W];
                s1_ahi_q <= bus.i_a[WIDTH-1:HALF_W];
                s1_bhi_q <= bus.i_b[WIDTH-1:HALF_W];
            end
        end
    end

    // Output register holds while stalled; a bubble only clears the valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            flags_q    <= FLAGS_RST;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                d_q     <= d_d;
                flags_q <= flags_d;
            end
        end
    end

    assign bus.o_d    = d_q;
    assign bus.o_bout = flags_q.bout;
    assign bus.o_n    = flags_q.n;
    assign bus.o_z    = flags_q.z;
    assign bus.o_v    = flags_q.v;

endmodule

// File: tb/tb_subtractor_bla_pipe.sv
// Directed and streaming checks for the pipelined borrow-lookahead subtractor.
module tb_subtractor_bla_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        bout;
        logic        n;
        logic        z;
        logic        v;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    subtractor_bla_pipe_if #(.WIDTH(32)) bus ();

    subtractor_bla_pipe #(.WIDTH(32), .GROUP(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [32:0] t;
        res_t r;
        t      = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        r.d    = t[31:0];
        r.bout = t[32];
        r.n    = t[31];
        r.z    = (t[31:0] == 32'd0);
        r.v    = (a[31] != b[31]) && (t[31] != a[31]);
        return r;
    endfunction

    function automatic res_t observe();
        return {bus.o_d, bus.o_bout, bus.o_n, bus.o_z, bus.o_v};
    endfunction

    // Single operation into an empty pipe; returns the result and the number
    // of rising edges from the accept edge to o_valid (0 if it never came).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         output res_t obs, output int lat);
        @(negedge clk);
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_bin   = bin;
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        lat = 0;
        obs = 'x;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.i_valid = 1'b0;
            if (bus.o_valid) begin
                lat = k;
                obs = observe();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid);
        end
        vectors++;
        if (observe() !== {32'h0, 4'b0010}) begin
            errors++; $display("FAIL reset_outputs: got %h want %h", observe(), {32'h0, 4'b0010});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready);
        end
    endtask

    task automatic test_basic();
        res_t obs;
        int   lat;
        do_op(32'd5, 32'd3, 1'b0, obs, lat);
        vectors++;
        if (obs !== {32'h0000_0002, 4'b0000}) begin
            errors++; $display("FAIL basic_5m3: got %h want %h", obs, {32'h2, 4'b0000});
        end
        vectors++;
        if (lat !== 2) begin
            errors++; $display("FAIL latency: got %0d want 2", lat);
        end
        do_op(32'd0, 32'd1, 1'b0, obs, lat);
        vectors++;
        if (obs !== {32'hFFFF_FFFF, 4'b1100}) begin
            errors++; $display("FAIL basic_0m1: got %h want %h", obs, {32'hFFFF_FFFF, 4'b1100});
        end
    endtask

    task automatic test_overflow();
        res_t obs;
        int   lat;
        do_op(32'h8000_0000, 32'd1, 1'b0, obs, lat);
        vectors++;
        if (obs !== {32'h7FFF_FFFF, 4'b0001}) begin
            errors++; $display("FAIL ovf_min_m1: got %h want %h", obs, {32'h7FFF_FFFF, 4'b0001});
        end
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, obs, lat);
        vectors++;
        if (obs !== {32'h8000_0000, 4'b1101}) begin
            errors++; $display("FAIL ovf_max_mneg1: got %h want %h", obs, {32'h8000_0000, 4'b1101});
        end
    endtask

    task automatic test_equal_operands();
        res_t obs;
        int   lat;
        do_op(32'h0000_1234, 32'h0000_1234, 1'b1, obs, lat);
        vectors++;
        if (obs !== {32'hFFFF_FFFF, 4'b1100}) begin
            errors++; $display("FAIL eq_bin1: got %h want %h", obs, {32'hFFFF_FFFF, 4'b1100});
        end
        do_op(32'h0000_1234, 32'h0000_1234, 1'b0, obs, lat);
        vectors++;
        if (obs !== {32'h0000_0000, 4'b0010}) begin
            errors++; $display("FAIL eq_bin0: got %h want %h", obs, {32'h0, 4'b0010});
        end
        do_op(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, obs, lat);
        vectors++;
        if (obs !== {32'hFFFF_FFFF, 4'b1100}) begin
            errors++; $display("FAIL eq_prop: got %h want %h", obs, {32'hFFFF_FFFF, 4'b1100});
        end
        do_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, obs, lat);
        vectors++;
        if (obs !== {32'h0000_0000, 4'b1010}) begin
            errors++; $display("FAIL wrap_full: got %h want %h", obs, {32'h0, 4'b1010});
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] av [4] = '{32'd10, 32'd0, 32'd100, 32'hFFFF_0000};
        logic [31:0] bv [4] = '{32'd3, 32'd1, 32'd100, 32'h0000_FFFF};
        logic        cv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        res_t        ev [4] = '{{32'h0000_0007, 4'b0000}, {32'hFFFF_FFFF, 4'b1100},
                                {32'hFFFF_FFFF, 4'b1100}, {32'hFFFE_0001, 4'b0100}};
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            bus.i_ready = (cyc >= 6);
            bus.i_valid = (sent < 4);
            if (sent < 4) begin
                bus.i_a   = av[sent];
                bus.i_b   = bv[sent];
                bus.i_bin = cv[sent];
            end
            #1;
            if (cyc == 5) begin
                vectors++;
                if (sent !== 2 || bus.o_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_stall: accepts %0d ready %b want 2 and 0", sent, bus.o_ready);
                end
                vectors++;
                if (bus.o_valid !== 1'b1 || observe() !== ev[0]) begin
                    errors++; $display("FAIL bp_hold: got %b/%h want 1/%h", bus.o_valid, observe(), ev[0]);
                end
            end
            if (bus.o_valid && bus.i_ready) begin
                vectors++;
                if (observe() !== ev[got]) begin
                    errors++; $display("FAIL bp_result%0d: got %h want %h", got, observe(), ev[got]);
                end
                got++;
            end
            if (bus.i_valid && bus.o_ready) sent++;
        end
        bus.i_valid = 1'b0;
        vectors++;
        if (got !== 4) begin
            errors++; $display("FAIL bp_count: got %0d results want 4", got);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.o_valid) got++;
        end
        vectors++;
        if (got !== 4) begin
            errors++; $display("FAIL bp_dup: got %0d results after drain want 4", got);
        end
    endtask

    task automatic test_throughput();
        res_t q [$];
        res_t exp_r;
        int   sent = 0;
        int   got  = 0;
        int   first_cyc = -1;
        int   last_cyc  = -1;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        bus.i_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                exp_r = (q.size() > 0) ? q.pop_front() : 'x;
                vectors++;
                if (observe() !== exp_r) begin
                    errors++; $display("FAIL stream%0d: got %h want %h", got, observe(), exp_r);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            bus.i_valid = (sent < 100);
            if (sent < 100) begin
                a = $urandom();
                b = $urandom();
                c = 1'($urandom_range(0, 1));
                bus.i_a   = a;
                bus.i_b   = b;
                bus.i_bin = c;
            end
            #1;
            if (bus.i_valid) begin
                if (bus.o_ready) begin
                    q.push_back(model(a, b, c));
                    sent++;
                end else begin
                    vectors++; errors++;
                    $display("FAIL stream_ready: got 0 want 1 at op %0d", sent);
                end
            end
        end
        bus.i_valid = 1'b0;
        vectors++;
        if (got !== 100 || (last_cyc - first_cyc) !== 99) begin
            errors++; $display("FAIL stream_rate: got %0d results over %0d cycles want 100 over 99",
                               got, last_cyc - first_cyc);
        end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_a = 32'd50; bus.i_b = 32'd8; bus.i_bin = 1'b0; bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_a = 32'd9; bus.i_b = 32'd4; bus.i_bin = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got o_valid %b want 1", bus.o_valid);
        end
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_z !== 1'b1 || bus.o_d !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got valid %b z %b d %h want 0 1 0",
                               bus.o_valid, bus.o_z, bus.o_d);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.o_valid) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            errors++; $display("FAIL mid_flush: got %0d stale results want 0", seen);
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_bin   = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_equal_operands();
        test_back_pressure();
        test_throughput();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
